combo_tracker: RTL and testbench

//  Producer side of the 4-bit combo bus that drives the LED combo bar.

---
 rtl/combo_tracker_if.sv | 36 +++
 rtl/combo_tracker.sv | 118 +++++++++++
 tb/tb_combo_tracker.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/combo_tracker_if.sv
// Combo bus between the game judge, the combo tracker and the LED bar / score logic.
// The tracker connects through the master modport; consumers and stimulus use slave.
interface combo_tracker_if #(
    parameter int WIDTH = 4
);
    logic             hit;
    logic             miss;
    logic             clear;
    logic             tick;
    logic [WIDTH-1:0] combo;
    logic [WIDTH-1:0] max_combo;
    logic             full;
    logic             combo_break;

    modport master (
        input  hit,
        input  miss,
        input  clear,
        input  tick,
        output combo,
        output max_combo,
        output full,
        output combo_break
    );

    modport slave (
        output hit,
        output miss,
        output clear,
        output tick,
        input  combo,
        input  max_combo,
        input  full,
        input  combo_break
    );
endinterface

// File: rtl/combo_tracker.sv
// Consecutive-hit counter with saturation, session best and a one-cycle break pulse.
// Optional inactivity timeout is enabled by defining COMBO_TIMEOUT_EN.
module combo_tracker #(
    parameter int WIDTH         = 4,
    parameter int MAX_COMBO     = 15,
    parameter int TIMEOUT_TICKS = 8,
    parameter int TMR_W         = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    combo_tracker_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHAIN = 2'd1,
        SAT   = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COMBO);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] combo_reg, combo_next;
    logic [WIDTH-1:0] max_reg, max_next;
    logic             full_reg, full_next;
    logic             break_reg, break_next;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic             timeout;

`ifdef COMBO_TIMEOUT_EN
    // The final tick of the window breaks the chain instead of advancing the timer.
    assign timeout = (state_reg != IDLE) && bus.tick && !bus.hit
                     && (timer_reg == TMR_W'(TIMEOUT_TICKS - 1));
`else
    assign timeout = 1'b0;
    logic [TMR_W-1:0] unused_timeout_cfg;
    logic             unused_tick;
    assign unused_timeout_cfg = TMR_W'(TIMEOUT_TICKS);
    assign unused_tick        = bus.tick;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            combo_reg <= '0;
            max_reg   <= '0;
            full_reg  <= 1'b0;
            break_reg <= 1'b0;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            combo_reg <= combo_next;
            max_reg   <= max_next;
            full_reg  <= full_next;
            break_reg <= break_next;
            timer_reg <= timer_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        combo_next = combo_reg;
        break_next = 1'b0;
        timer_next = timer_reg;

        if (bus.clear) begin
            state_next = IDLE;
            combo_next = '0;
            timer_next = '0;
        end else if (bus.miss) begin
            // A miss with an empty chain is a no-op, and it still masks a simultaneous hit.
            if (state_reg != IDLE) begin
                state_next = IDLE;
                combo_next = '0;
                break_next = 1'b1;
                timer_next = '0;
            end
        end else if (bus.hit) begin
            timer_next = '0;
            case (state_reg)
                IDLE: begin
                    combo_next = WIDTH'(1);
                    state_next = (MAX_VAL == WIDTH'(1)) ? SAT : CHAIN;
                end
                CHAIN: begin
                    combo_next = combo_reg + WIDTH'(1);
                    state_next = (combo_next == MAX_VAL) ? SAT : CHAIN;
                end
                SAT: begin
                    combo_next = MAX_VAL;
                    state_next = SAT;
                end
                default: begin
                    combo_next = '0;
                    state_next = IDLE;
                end
            endcase
        end else if (timeout) begin
            state_next = IDLE;
            combo_next = '0;
            break_next = 1'b1;
            timer_next = '0;
        end else begin
`ifdef COMBO_TIMEOUT_EN
            if (state_reg != IDLE && bus.tick) begin
                timer_next = timer_reg + TMR_W'(1);
            end
`endif
        end

        max_next  = bus.clear ? '0 : ((combo_next > max_reg) ? combo_next : max_reg);
        full_next = (combo_next == MAX_VAL);
    end

    assign bus.combo       = combo_reg;
    assign bus.max_combo   = max_reg;
    assign bus.full        = full_reg;
    assign bus.combo_break = break_reg;
endmodule

// File: tb/tb_combo_tracker.sv
// Directed bench for combo_tracker; timeout vectors follow the COMBO_TIMEOUT_EN build option.
module tb_combo_tracker;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    combo_tracker_if #(.WIDTH(4)) bus ();

    combo_tracker #(
        .WIDTH(4),
        .MAX_COMBO(15),
        .TIMEOUT_TICKS(8),
        .TMR_W(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the given pulses; outputs are stable 1 ns after the edge.
    task automatic cycle(input logic h, input logic m, input logic c, input logic t);
        @(negedge clk);
        bus.hit   = h;
        bus.miss  = m;
        bus.clear = c;
        bus.tick  = t;
        @(posedge clk);
        #1;
        bus.hit   = 1'b0;
        bus.miss  = 1'b0;
        bus.clear = 1'b0;
        bus.tick  = 1'b0;
        $display("t=%0t hit=%b miss=%b clear=%b tick=%b -> combo=%0d max=%0d full=%b brk=%b",
                 $time, h, m, c, t, bus.combo, bus.max_combo, bus.full, bus.combo_break);
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        bus.hit   = 1'b0;
        bus.miss  = 1'b0;
        bus.clear = 1'b0;
        bus.tick  = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_combo", int'(bus.combo), 0);
        check("rst_max", int'(bus.max_combo), 0);
        check("rst_full", int'(bus.full), 0);
        check("rst_break", int'(bus.combo_break), 0);
        rst_n = 1'b1;

        // 1: three hits
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            check("t1_combo", int'(bus.combo), i);
            check("t1_break", int'(bus.combo_break), 0);
        end
        check("t1_max", int'(bus.max_combo), 3);
        check("t1_full", int'(bus.full), 0);

        // 2: saturation after 15 hits, no wrap
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("t2_clr_combo", int'(bus.combo), 0);
        check("t2_clr_break", int'(bus.combo_break), 0);
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            check("t2_combo", int'(bus.combo), (i < 15) ? i : 15);
            check("t2_full", int'(bus.full), (i >= 15) ? 1 : 0);
            check("t2_break", int'(bus.combo_break), 0);
        end
        check("t2_max", int'(bus.max_combo), 15);

        // 3: break pulse, immediate restart, best preserved
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        hits(5);
        check("t3_combo5", int'(bus.combo), 5);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("t3_miss_combo", int'(bus.combo), 0);
        check("t3_miss_break", int'(bus.combo_break), 1);
        check("t3_miss_max", int'(bus.max_combo), 5);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_restart_combo", int'(bus.combo), 1);
        check("t3_restart_break", int'(bus.combo_break), 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_combo2", int'(bus.combo), 2);
        check("t3_max", int'(bus.max_combo), 5);

        // 4: hit+miss together, then miss on an empty chain
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        hits(4);
        check("t4_combo4", int'(bus.combo), 4);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("t4_hm_combo", int'(bus.combo), 0);
        check("t4_hm_break", int'(bus.combo_break), 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_pulse_len", int'(bus.combo_break), 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("t4_idle_miss_combo", int'(bus.combo), 0);
        check("t4_idle_miss_break", int'(bus.combo_break), 0);

        // 5: timeout
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        hits(2);
`ifdef COMBO_TIMEOUT_EN
        for (int i = 1; i <= 7; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_pre_combo", int'(bus.combo), 2);
        check("t5_pre_break", int'(bus.combo_break), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_to_combo", int'(bus.combo), 0);
        check("t5_to_break", int'(bus.combo_break), 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_to_pulse_len", int'(bus.combo_break), 0);
        check("t5_idle_tick_combo", int'(bus.combo), 0);
        hits(2);
        for (int i = 1; i <= 6; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("t5_hit_tick_combo", int'(bus.combo), 3);
        check("t5_hit_tick_break", int'(bus.combo_break), 0);
        for (int i = 1; i <= 7; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_restart_combo", int'(bus.combo), 3);
        check("t5_restart_break", int'(bus.combo_break), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_restart_to_combo", int'(bus.combo), 0);
        check("t5_restart_to_break", int'(bus.combo_break), 1);
`else
        for (int i = 1; i <= 100; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            if (bus.combo_break !== 1'b0) check("t5_tick_break", int'(bus.combo_break), 0);
        end
        check("t5_tick_combo", int'(bus.combo), 2);
        check("t5_tick_break_end", int'(bus.combo_break), 0);
`endif

        // 6: clear, then reset, mid-chain
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        hits(9);
        check("t6_combo9", int'(bus.combo), 9);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("t6_clr_combo", int'(bus.combo), 0);
        check("t6_clr_max", int'(bus.max_combo), 0);
        check("t6_clr_break", int'(bus.combo_break), 0);
        check("t6_clr_full", int'(bus.full), 0);
        hits(9);
        check("t6_max9", int'(bus.max_combo), 9);
        @(negedge clk);
        rst_n = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        check("t6_rst_combo", int'(bus.combo), 0);
        check("t6_rst_max", int'(bus.max_combo), 0);
        check("t6_rst_full", int'(bus.full), 0);
        check("t6_rst_break", int'(bus.combo_break), 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_post_rst_combo", int'(bus.combo), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
